cb_seg_stream: RTL and testbench
================================

// Module: cb_seg_stream
// PURPOSE
// Parametrised successor of the byte-serial code-block segmenter: splits one transport block (TB) into C code blocks
// per a per-TB descriptor, inserts leading filler words, appends a per-block CRC (CRC24B by default) when C>1,
// and streams tagged words to the interleaver/encoder FIFOs with full valid/ready backpressure on both sides.
// PARAMETERS
// DW        8          data word width in bits; CRC_W % DW == 0 required
// CRC_W     24         CRC width in bits
// CRC_POLY  24'h800063 generator polynomial (CRC24B), MSB-first, init 0, no final XOR
// CB_W      6          width of code-block count/index fields
// K_W       11         width of block-size/filler fields, in DW-bit words
// PORTS
// clk          in   1     clock
// reset        in   1     synchronous, active-low reset
// desc_valid   in   1     descriptor valid
// desc_ready   out  1     descriptor accepted when desc_valid&desc_ready
// desc_c       in   CB_W  number of code blocks C
// desc_cminus  in   CB_W  number of K- blocks (first in order)
// desc_kplus   in   K_W   K+ in words (filler+data+CRC)
// desc_kminus  in   K_W   K- in words
// desc_fill    in   K_W   filler words F (block 0 only)
// in_valid     in   1     TB data word valid
// in_ready     out  1     TB data word consumed when in_valid&in_ready
// in_data      in   DW    TB data word
// out_valid    out  1     output word valid
// out_ready    in   1     downstream accepts word
// out_data     out  DW    filler (0), TB data or CRC word
// out_start    out  1     first word of a code block
// out_last     out  1     last word of a code block
// out_filler   out  1     word is filler
// out_crc      out  1     word is CRC
// out_size     out  1     1 = block is K+, 0 = K-
// out_cb_idx   out  CB_W  code-block index 0..C-1
// tb_done      out  1     1-cycle pulse when last word of TB is accepted downstream
// desc_err     out  1     sticky; set on rejected descriptor, cleared by reset only
// BEHAVIOUR
// - Reset (reset==0 at clk edge): state IDLE, all outputs 0 except desc_ready=1; in-flight TB discarded, CRC cleared.
// - adv = ~out_valid | out_ready. Output register loads only on adv; all out_* hold stable while out_valid&~out_ready.
// - FSM: IDLE -> FILL -> DATA -> CRC -> (next block: FILL/DATA) ... -> IDLE. FILL skipped if block!=0 or F==0; CRC skipped if C==1.
// - IDLE: desc_ready=1. Accept latches fields; CW = (C>1) ? CRC_W/DW : 0. Reject (desc_err=1, stay IDLE) if C==0,
//   cminus>C, or any used block has K < CW (+F for block 0). No data consumed for rejected descriptors.
// - Block b uses K- if b<cminus else K+; data words = K - CW - (b==0 ? F : 0), may be 0.
// - FILL: emits zero words, out_filler=1, in_ready=0. DATA: in_ready = adv; word transfers only on in_valid&adv;
//   input->output latency 1 cycle. No bubble state between phases; back-to-back blocks at full rate.
// - CRC engine: DW bits/cycle, cleared at each block's first word, updated with every filler/data word as it loads
//   into the output register (filler counts as zeros). CRC phase emits CW words MSB first (crc[CRC_W-1 -: DW] first); no update.
// - out_start on block's first word; out_last on its final word (final data word when C==1); both may be 1 if K==1.
// - tb_done pulses the cycle after the TB's final word handshakes; desc_ready returns to 1 the same cycle (IDLE).
// - Descriptor offered mid-TB waits (desc_ready=0). Extra input words past the TB total are not consumed.
// - Word counters are K_W wide; no wrap within a legal descriptor; block index counts 0..C-1 then returns to IDLE.
// TESTING
// 1 DW=8; C=1,F=1,K+=5; data 11 22 33 44 -> 00(filler,start) 11 22 33 44(last), no CRC, tb_done once.
// 2 C=2,cminus=1,K-=6,K+=7,F=1, data all 00 x6 -> b0: 00f 00 00 + CRC 00 00 00 (size=0); b1: 00x4 + 00 00 00 (size=1, idx=1).
// 3 Same as 2 with random data, random out_ready/in_valid gaps -> byte-exact vs C model (CRC24B), outputs stable while stalled.
// 4 C=0, then C=2 K-=2 F=0 -> desc_err=1, no in_ready, desc_ready stays 1; valid descriptor afterwards completes normally.
// 5 reset low mid block 1 of scenario 3 -> next cycle out_valid=0, desc_ready=1; rerun TB gives identical output.
// 6 Two TBs back-to-back, desc held valid during first -> second accepted cycle of tb_done, no lost/duplicated words.

Source files
------------

// File: rtl/cb_seg_stream.sv
// Code-block segmenter: splits a transport block into C code blocks, prepends filler, appends per-block CRC.
// Latency: one cycle from an accepted input word to the output register; no bubbles between phases or blocks.
// Backpressure: output register advances only when empty or accepted; in_ready follows it during data phases.
module cb_seg_stream #(
  parameter int DW = 8,
  parameter int CRC_W = 24,
  parameter logic [CRC_W-1:0] CRC_POLY = 24'h800063,
  parameter int CB_W = 6,
  parameter int K_W = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            desc_valid,
  output logic            desc_ready,
  input  logic [CB_W-1:0] desc_c,
  input  logic [CB_W-1:0] desc_cminus,
  input  logic [K_W-1:0]  desc_kplus,
  input  logic [K_W-1:0]  desc_kminus,
  input  logic [K_W-1:0]  desc_fill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_start,
  output logic            out_last,
  output logic            out_filler,
  output logic            out_crc,
  output logic            out_size,
  output logic [CB_W-1:0] out_cb_idx,
  output logic            tb_done,
  output logic            desc_err
);

  localparam logic [K_W-1:0] CW_WORDS = K_W'(CRC_W / DW);

  // DRAIN holds the TB's final word until it is accepted downstream.
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_DATA, S_CRC, S_DRAIN} state_t;

  typedef struct packed {
    state_t         st;
    logic [K_W-1:0] n;
  } entry_t;

  // First phase of block b and its word count: filler if any, else data if any, else straight to CRC.
  function automatic entry_t blk_entry(input logic [CB_W-1:0] b, input logic [CB_W-1:0] cm,
                                       input logic [K_W-1:0] kp, input logic [K_W-1:0] km,
                                       input logic [K_W-1:0] f, input logic [K_W-1:0] cw);
    logic [K_W-1:0] k;
    logic [K_W-1:0] fb;
    logic [K_W-1:0] nd;
    entry_t e;
    k  = (b < cm) ? km : kp;
    fb = (b == '0) ? f : '0;
    nd = k - cw - fb;
    if (fb != '0) begin
      e.st = S_FILL; e.n = fb;
    end else if (nd != '0) begin
      e.st = S_DATA; e.n = nd;
    end else begin
      e.st = S_CRC;  e.n = cw;
    end
    return e;
  endfunction

  // MSB-first serial CRC over one DW-bit word.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic [DW-1:0] d);
    logic [CRC_W-1:0] r;
    logic fb;
    r = c;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = {r[CRC_W-2:0], 1'b0};
      if (fb) r = r ^ CRC_POLY;
    end
    return r;
  endfunction

  state_t          state, state_n;
  logic [CB_W-1:0] blk, blk_n;
  logic [K_W-1:0]  cnt, cnt_n;
  logic            first, first_n;

  logic [CB_W-1:0] r_c, r_cm;
  logic [K_W-1:0]  r_kp, r_km, r_f, r_cw;
  logic [CRC_W-1:0] crc, crc_n;

  logic            adv, load_vld, do_load, word_last, end_blk, last_blk;
  logic [DW-1:0]   word;
  logic [K_W-1:0]  cur_k, d0;
  entry_t          nxt, e0;

  logic [K_W-1:0]  d_cw, b0_k;
  logic [K_W:0]    need0;
  logic            km_used, kp_used, bad, desc_ok, desc_bad;

  assign adv        = ~out_valid | out_ready;
  assign desc_ready = (state == S_IDLE);
  assign in_ready   = (state == S_DATA) & adv;
  assign load_vld   = (state == S_FILL) | (state == S_CRC) | ((state == S_DATA) & in_valid);
  assign do_load    = adv & load_vld;
  assign cur_k      = (blk < r_cm) ? r_km : r_kp;
  assign d0         = cur_k - r_cw - r_f;
  assign last_blk   = (blk == r_c - 1'b1);
  assign nxt        = blk_entry(blk + 1'b1, r_cm, r_kp, r_km, r_f, r_cw);

  // Descriptor screening: every block in use must hold its CRC (and block 0 its filler) and at least one word.
  assign d_cw     = (desc_c > CB_W'(1)) ? CW_WORDS : '0;
  assign km_used  = (desc_cminus != '0);
  assign kp_used  = (desc_cminus < desc_c);
  assign b0_k     = km_used ? desc_kminus : desc_kplus;
  assign need0    = {1'b0, d_cw} + {1'b0, desc_fill};
  assign bad      = (desc_c == '0) | (desc_cminus > desc_c)
                  | (km_used & ((desc_kminus < d_cw) | (desc_kminus == '0)))
                  | (kp_used & ((desc_kplus < d_cw) | (desc_kplus == '0)))
                  | ({1'b0, b0_k} < need0);
  assign desc_ok  = desc_valid & desc_ready & ~bad;
  assign desc_bad = desc_valid & desc_ready & bad;
  assign e0       = blk_entry('0, desc_cminus, desc_kplus, desc_kminus, desc_fill, d_cw);

  always_comb begin
    unique case (state)
      S_FILL:  word = '0;
      S_DATA:  word = in_data;
      S_CRC:   word = crc[CRC_W-1 -: DW];
      default: word = '0;
    endcase
    crc_n = (state == S_CRC) ? (crc << DW) : crc_step(first ? '0 : crc, word);
  end

  // FSM state register: phase, block index, words left in phase, block-start marker.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      blk   <= '0;
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_n;
      blk   <= blk_n;
      cnt   <= cnt_n;
      first <= first_n;
    end
  end

  // Next phase: count down the current phase on each loaded word, then chain filler -> data -> CRC -> next block.
  always_comb begin
    state_n   = state;
    blk_n     = blk;
    cnt_n     = cnt;
    first_n   = first;
    word_last = 1'b0;
    end_blk   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (desc_ok) begin
          state_n = e0.st;
          cnt_n   = e0.n;
          blk_n   = '0;
          first_n = 1'b1;
        end
      end
      S_FILL, S_DATA, S_CRC: begin
        if (do_load) begin
          first_n = 1'b0;
          if (cnt != K_W'(1)) begin
            cnt_n = cnt - 1'b1;
          end else begin
            if (state == S_FILL && d0 != '0) begin
              state_n = S_DATA; cnt_n = d0;
            end else if (state != S_CRC && r_cw != '0) begin
              state_n = S_CRC;  cnt_n = r_cw;
            end else begin
              end_blk = 1'b1;
            end
            if (end_blk) begin
              word_last = 1'b1;
              first_n   = 1'b1;
              if (last_blk) begin
                state_n = S_DRAIN;
              end else begin
                blk_n   = blk + 1'b1;
                state_n = nxt.st;
                cnt_n   = nxt.n;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: descriptor latch, error flag, CRC accumulator, output register and done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_c <= '0; r_cm <= '0; r_kp <= '0; r_km <= '0; r_f <= '0; r_cw <= '0;
      crc        <= '0;
      desc_err   <= 1'b0;
      tb_done    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_start  <= 1'b0;
      out_last   <= 1'b0;
      out_filler <= 1'b0;
      out_crc    <= 1'b0;
      out_size   <= 1'b0;
      out_cb_idx <= '0;
    end else begin
      tb_done <= (state == S_DRAIN) & out_ready;
      if (desc_bad) desc_err <= 1'b1;
      if (desc_ok) begin
        r_c <= desc_c; r_cm <= desc_cminus; r_kp <= desc_kplus;
        r_km <= desc_kminus; r_f <= desc_fill; r_cw <= d_cw;
      end
      if (do_load) crc <= crc_n;
      if (adv) begin
        out_valid <= load_vld;
        if (load_vld) begin
          out_data   <= word;
          out_start  <= first;
          out_last   <= word_last;
          out_filler <= (state == S_FILL);
          out_crc    <= (state == S_CRC);
          out_size   <= (blk >= r_cm);
          out_cb_idx <= blk;
        end
      end
    end
  end

endmodule

// File: tb/tb_cb_seg_stream.sv
// Bench for cb_seg_stream: block-level model (long-division CRC24B) feeding an expected-word queue.
// One monitor/driver loop compares every accepted word, checks stall stability and tb_done timing.
// Directed scenarios: single block, zero data, random data with stalls, rejects, mid-TB reset, back-to-back TBs.
`timescale 1ns/1ps
module tb_cb_seg_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       desc_valid = 1'b0;
  logic       desc_ready;
  logic [5:0] desc_c = '0, desc_cminus = '0;
  logic [10:0] desc_kplus = '0, desc_kminus = '0, desc_fill = '0;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_start, out_last, out_filler, out_crc, out_size;
  logic [5:0] out_cb_idx;
  logic       tb_done, desc_err;
  logic [18:0] out_bus;

  cb_seg_stream dut (
    .clk(clk), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_c(desc_c), .desc_cminus(desc_cminus),
    .desc_kplus(desc_kplus), .desc_kminus(desc_kminus), .desc_fill(desc_fill),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_start(out_start),
    .out_last(out_last), .out_filler(out_filler), .out_crc(out_crc), .out_size(out_size),
    .out_cb_idx(out_cb_idx), .tb_done(tb_done), .desc_err(desc_err)
  );

  always #5 clk = ~clk;

  assign out_bus = {out_data, out_start, out_last, out_filler, out_crc, out_size, out_cb_idx};

  typedef struct {
    logic [18:0] w;
    bit          tb_end;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  in_q[$];
  logic [7:0]  dbuf [0:63];
  int          n_tests = 0;
  int          n_fail = 0;
  bit          en = 1'b0;
  bit          rnd = 1'b0;
  bit          seen_idx1 = 1'b0;
  bit          stall = 1'b0;
  bit          pend = 1'b0;
  logic [18:0] held = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // CRC as the remainder of M(x)*x^24 divided by the generator.
  function automatic logic [23:0] crc_div(input logic [7:0] m [0:63], input int n);
    bit b [0:64*8+23];
    logic [24:0] g;
    logic [23:0] r;
    int len;
    g = {1'b1, 24'h800063};
    len = n * 8 + 24;
    for (int i = 0; i < len; i++) b[i] = (i < n * 8) ? m[i/8][7-(i%8)] : 1'b0;
    for (int i = 0; i + 24 < len; i++)
      if (b[i]) for (int j = 0; j < 25; j++) b[i+j] ^= g[24-j];
    for (int j = 0; j < 24; j++) r[23-j] = b[len-24+j];
    return r;
  endfunction

  // Expected words of one TB whose data starts at dbuf[off].
  task automatic model_tb(input int c, input int cm, input int kp, input int km, input int f, input int off);
    int p, cw, k, fb, nd, n;
    logic [7:0] bw [0:63];
    logic [23:0] crc;
    exp_t e;
    p = off;
    cw = (c > 1) ? 3 : 0;
    for (int b = 0; b < c; b++) begin
      k = (b < cm) ? km : kp;
      fb = (b == 0) ? f : 0;
      nd = k - cw - fb;
      n = 0;
      for (int i = 0; i < fb; i++) begin bw[n] = 8'h00; n++; end
      for (int i = 0; i < nd; i++) begin bw[n] = dbuf[p]; n++; p++; end
      crc = crc_div(bw, n);
      for (int j = 0; j < cw; j++) begin bw[n] = crc[23-8*j -: 8]; n++; end
      for (int i = 0; i < k; i++) begin
        e.w = {bw[i], i == 0, i == k - 1, i < fb, i >= k - cw, b >= cm, 6'(b)};
        e.tb_end = (b == c - 1) && (i == k - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_in(input int off, input int n);
    for (int i = 0; i < n; i++) in_q.push_back(dbuf[off+i]);
  endtask

  task automatic send_desc(input int c, input int cm, input int kp, input int km, input int f, input bit want_done);
    int t;
    @(posedge clk); #2;
    desc_c = 6'(c); desc_cminus = 6'(cm); desc_kplus = 11'(kp); desc_kminus = 11'(km); desc_fill = 11'(f);
    desc_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!desc_ready && t < 1000);
    if (!desc_ready) chk("desc_accept_timeout", 0, 1);
    if (want_done) chk("accept_on_tb_done", tb_done, 1);
    @(posedge clk); #2;
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) chk(name, exp_q.size(), 0);
    repeat (4) @(posedge clk);
  endtask

  // Monitor at negedge, drive at posedge+1.
  initial begin
    exp_t e;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (en) begin
        if (stall) chk("stall_stable", out_bus, held);
        chk("tb_done", tb_done, pend);
        pend = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", out_bus, 19'h7ffff);
          end else begin
            e = exp_q.pop_front();
            chk("word", out_bus, e.w);
            pend = e.tb_end;
            if (out_cb_idx == 6'd1) seen_idx1 = 1'b1;
          end
        end
        stall = out_valid && !out_ready;
        held = out_bus;
        if (in_valid && in_ready && in_q.size() != 0) void'(in_q.pop_front());
      end else begin
        stall = 1'b0;
        pend = 1'b0;
      end
      @(posedge clk); #1;
      if (en) begin
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_valid = (in_q.size() != 0) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
        in_data = (in_q.size() != 0) ? in_q[0] : 8'h00;
      end else begin
        out_ready = 1'b0;
        in_valid = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] pm [0:63];
    logic [7:0] s1w [0:4];
    logic [7:0] acc;
    int t;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tb_done", tb_done, 0);
    chk("rst_desc_err", desc_err, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    en = 1'b1;

    // 1: C=1, F=1, K+=5, no CRC
    dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33; dbuf[3] = 8'h44;
    model_tb(1, 0, 5, 5, 1, 0);
    s1w = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    chk("s1_model_len", exp_q.size(), 5);
    for (int i = 0; i < 5; i++) chk("s1_model_data", exp_q[i].w[18:11], s1w[i]);
    chk("s1_model_tags", {exp_q[0].w[10], exp_q[0].w[8], exp_q[4].w[9], exp_q[4].w[7]}, 4'b1110);
    push_in(0, 4);
    send_desc(1, 0, 5, 5, 1, 1'b0);
    wait_done("s1_timeout");

    // 2: C=2, cminus=1, K-=6, K+=7, F=1, all-zero data
    for (int i = 0; i < 6; i++) dbuf[i] = 8'h00;
    model_tb(2, 1, 7, 6, 1, 0);
    chk("s2_model_len", exp_q.size(), 13);
    acc = 8'h00;
    for (int i = 0; i < 13; i++) acc = acc | exp_q[i].w[18:11];
    chk("s2_model_zero", acc, 0);
    chk("s2_model_b0_last", {exp_q[5].w[9], exp_q[5].w[7], exp_q[5].w[6]}, 3'b110);
    chk("s2_model_b1_start", {exp_q[6].w[10], exp_q[6].w[6], exp_q[6].w[5:0]}, 8'b11_000001);
    push_in(0, 6);
    send_desc(2, 1, 7, 6, 1, 1'b0);
    wait_done("s2_timeout");

    // 3: random data and stalls
    pm[0] = 8'h01;
    chk("crc_pin_01", crc_div(pm, 1), 24'h800063);
    pm[0] = 8'h80;
    chk("crc_pin_80", crc_div(pm, 1), 24'h802121);
    rnd = 1'b1;
    for (int i = 0; i < 6; i++) dbuf[i] = 8'($urandom_range(0, 255));
    model_tb(2, 1, 7, 6, 1, 0);
    push_in(0, 6);
    send_desc(2, 1, 7, 6, 1, 1'b0);
    wait_done("s3_timeout");

    // 4: rejected descriptors consume nothing; a valid one completes afterwards
    rnd = 1'b0;
    in_q.push_back(8'h5A);
    send_desc(0, 0, 5, 5, 0, 1'b0);
    @(negedge clk);
    chk("s4_err_set", desc_err, 1);
    chk("s4_ready_c0", desc_ready, 1);
    chk("s4_no_in_c0", in_ready, 0);
    send_desc(2, 1, 8, 2, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("s4_ready_k", desc_ready, 1);
    chk("s4_no_in_k", in_ready, 0);
    chk("s4_in_kept", in_q.size(), 1);
    dbuf[0] = 8'h5A; dbuf[1] = 8'h01; dbuf[2] = 8'h80; dbuf[3] = 8'hFF;
    model_tb(1, 0, 4, 4, 0, 0);
    push_in(1, 3);
    send_desc(1, 0, 4, 4, 0, 1'b0);
    wait_done("s4_timeout");
    chk("s4_err_sticky", desc_err, 1);

    // 5: reset in block 1, then rerun the same TB
    rnd = 1'b1;
    for (int i = 0; i < 6; i++) dbuf[i] = 8'($urandom_range(0, 255));
    model_tb(2, 1, 7, 6, 1, 0);
    push_in(0, 6);
    seen_idx1 = 1'b0;
    send_desc(2, 1, 7, 6, 1, 1'b0);
    t = 0;
    while (!seen_idx1 && t < 2000) begin @(negedge clk); t++; end
    chk("s5_reached_b1", seen_idx1, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("s5_rst_out_valid", out_valid, 0);
    chk("s5_rst_desc_ready", desc_ready, 1);
    chk("s5_rst_desc_err", desc_err, 0);
    exp_q.delete();
    in_q.delete();
    @(posedge clk); #2;
    reset = 1'b1;
    en = 1'b1;
    model_tb(2, 1, 7, 6, 1, 0);
    push_in(0, 6);
    send_desc(2, 1, 7, 6, 1, 1'b0);
    wait_done("s5_timeout");

    // 6: back-to-back TBs, second descriptor waits and is taken on the tb_done cycle
    for (int i = 0; i < 6; i++) dbuf[i] = 8'($urandom_range(0, 255));
    dbuf[6] = 8'hA1; dbuf[7] = 8'hB2; dbuf[8] = 8'hC3; dbuf[9] = 8'hD4;
    model_tb(2, 1, 7, 6, 1, 0);
    model_tb(1, 0, 5, 5, 1, 6);
    push_in(0, 10);
    send_desc(2, 1, 7, 6, 1, 1'b0);
    send_desc(1, 0, 5, 5, 1, 1'b1);
    wait_done("s6_timeout");
    chk("s6_in_drained", in_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
